stump_mem_responder: RTL and testbench
======================================

// Module: stump_mem_responder
// PURPOSE
//  Memory-side responder for the Stump memory bus: services the mem_ren/mem_wen
//  requests raised by the control decoder during FETCH and MEMORY states.
//  Holds a word-addressed 16-bit RAM plus one memory-mapped output register,
//  with a configurable number of wait states and a mem_ready completion strobe.
//  Sits between the Stump datapath address/data buses and the board I/O.
// PARAMETERS
//  ADDR_W      8        RAM index width; RAM depth = 2**ADDR_W words of 16 bits
//  WAIT_CYCLES 0        extra wait cycles inserted before mem_ready (0..15)
//  IO_ADDR     16'hFF00 full 16-bit address of the memory-mapped output register
// PORTS
//  clk         in   1   system clock, all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  mem_ren     in   1   read request from the control decoder
//  mem_wen     in   1   write request from the control decoder
//  address     in   16  word address from the datapath
//  data_out    in   16  write data from the processor
//  data_in     out  16  read data returned to the processor
//  mem_ready   out  1   one-cycle strobe: transaction complete
//  io_out      out  16  memory-mapped output register contents
//  bus_err     out  1   sticky protocol-error flag
// BEHAVIOUR
//  Reset: data_in=0, mem_ready=0, io_out=0, bus_err=0, FSM->IDLE, wait count 0.
//   RAM contents not cleared by reset.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE: if mem_ren|mem_wen, capture address, data_out, ren, wen into holding regs;
//   WAIT_CYCLES==0 -> RESP, else load counter with WAIT_CYCLES -> WAIT.
//  WAIT: counter decrements each cycle; on reaching 1 -> RESP. Request inputs
//   ignored; captured values used (address changes mid-wait have no effect).
//  RESP (exactly one cycle, mem_ready=1), then -> IDLE unconditionally:
//   read : data_in <= RAM[addr[ADDR_W-1:0]], or io_out if addr==IO_ADDR;
//          data_in valid in the mem_ready cycle and held until next read.
//   write: addr==IO_ADDR -> io_out <= data; else RAM[addr[ADDR_W-1:0]] <= data.
//          Write commits at end of the RESP cycle; io_out visible next cycle.
//  Latency: request seen in IDLE at cycle T -> mem_ready high in cycle
//   T+1+WAIT_CYCLES.
//  Handshake: requester holds enables until mem_ready, drops them the cycle
//   after. An enable still high in IDLE after RESP starts a NEW transaction.
//  Address decode: IO_ADDR compares all 16 bits; all other addresses alias into
//   RAM using the low ADDR_W bits (upper bits ignored, wrap-around).
//  mem_ren&mem_wen together in IDLE: protocol error -> bus_err<=1 (sticky until
//   rst), transaction proceeds as a no-op: no write, data_in<=0, mem_ready pulsed
//   normally.
//  Reset mid-transaction (WAIT or RESP): aborted, no write performed, no ready.
//  mem_ready is never high in two consecutive cycles.
// TESTING
//  1 WAIT_CYCLES=0: write 16'h1234 to 16'h0010, then read 16'h0010 -> mem_ready
//    one cycle after each request, data_in=16'h1234 in read ready cycle.
//  2 WAIT_CYCLES=3: read request at T -> mem_ready only at T+4; change address
//    during WAIT -> data from originally captured address.
//  3 Write 16'hBEEF to IO_ADDR -> io_out=16'hBEEF cycle after RESP; RAM[8'h00]
//    unchanged; read IO_ADDR returns 16'hBEEF.
//  4 ADDR_W=8: write 16'h00AA to 16'h0105, read 16'h0005 -> 16'h00AA (alias).
//  5 mem_ren=mem_wen=1 at 16'h0020 holding 16'h5555 -> bus_err=1, data_in=0,
//    RAM[16'h0020] still 16'h5555; bus_err stays 1 until rst.
//  6 WAIT_CYCLES=3, write pending, assert rst in WAIT -> no mem_ready, target
//    word unchanged, all outputs 0 next cycle, next request served normally.

Source files
------------

// File: rtl/stump_mem_responder.sv
// stump_mem_responder: Stump memory-bus responder with word RAM, one memory-mapped output register and wait states
module stump_mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] IO_ADDR     = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  output logic        mem_ready,
  output logic [15:0] io_out,
  output logic        bus_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, wdat_q, data_in_q, data_in_d, io_q, cur_addr, rd_data;
  logic        ren_q, wen_q, err_q, cur_ren, cur_wen, cap, do_wr;
  logic [15:0] ram [2**ADDR_W];
  assign cap      = state_q == S_IDLE && (mem_ren || mem_wen);
  assign cur_addr = cap ? address : addr_q;
  assign cur_ren  = cap ? mem_ren : ren_q;
  assign cur_wen  = cap ? mem_wen : wen_q;
  assign rd_data  = cur_addr == IO_ADDR ? io_q : ram[cur_addr[ADDR_W-1:0]];
  assign do_wr    = state_q == S_RESP && wen_q && !ren_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      data_in_q <= '0;
      io_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_in_q <= data_in_d;
      if (cap) begin
        addr_q <= address;
        wdat_q <= data_out;
        ren_q  <= mem_ren;
        wen_q  <= mem_wen;
      end
      if (cap && mem_ren && mem_wen) err_q <= 1'b1;
      if (do_wr && addr_q == IO_ADDR) io_q <= wdat_q;
    end
  end
  // RAM has no reset; a reset edge suppresses the pending commit
  always_ff @(posedge clk)
    if (!rst && do_wr && addr_q != IO_ADDR) ram[addr_q[ADDR_W-1:0]] <= wdat_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cap) begin
      state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
      cnt_d   = 4'(WAIT_CYCLES);
    end else if (state_q == S_WAIT) begin
      state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
      cnt_d   = cnt_q - 4'd1;
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
  end
  // read data is latched on entry to RESP so it is valid during the ready cycle
  always_comb begin
    data_in_d = state_d != S_RESP ? data_in_q : (cur_ren && cur_wen) ? 16'h0000 : cur_ren ? rd_data : data_in_q;
    mem_ready = state_q == S_RESP;
    data_in   = data_in_q;
    io_out    = io_q;
    bus_err   = err_q;
  end
endmodule

// File: tb/tb_stump_mem_responder.sv
// tb_stump_mem_responder: randomized self-checking bench for zero and three wait-state responders
module tb_stump_mem_responder;
  localparam logic [15:0] IO = 16'hFF00;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_s [2], ren_s [2], wen_s [2], rdy [2], err_o [2];
  logic [15:0] addr_s [2], dout_s [2], din_o [2], io_o [2];
  stump_mem_responder #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst_s[0]), .mem_ren(ren_s[0]), .mem_wen(wen_s[0]), .address(addr_s[0]),
    .data_out(dout_s[0]), .data_in(din_o[0]), .mem_ready(rdy[0]), .io_out(io_o[0]), .bus_err(err_o[0]));
  stump_mem_responder #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst_s[1]), .mem_ren(ren_s[1]), .mem_wen(wen_s[1]), .address(addr_s[1]),
    .data_out(dout_s[1]), .data_in(din_o[1]), .mem_ready(rdy[1]), .io_out(io_o[1]), .bus_err(err_o[1]));
  int n_cmp = 0, n_err = 0;
  logic [15:0] ram_m [2][256];
  logic [15:0] io_m [2], din_m [2];
  bit          err_m [2];
  int          lat;
  logic [15:0] rd;
  logic        gap;
  function automatic int exp_lat(input int d);
    return d == 0 ? 1 : 4;
  endfunction
  // one full handshake; the address/data are scrambled after capture to prove they are held
  task automatic txn(input int d, input bit r, input bit w, input logic [15:0] a, input logic [15:0] wd,
                     output int l, output logic [15:0] rdat, output logic g);
    ren_s[d] = r; wen_s[d] = w; addr_s[d] = a; dout_s[d] = wd; l = 0;
    do begin
      @(posedge clk); #1; l++;
      addr_s[d] = a ^ 16'h0040; dout_s[d] = ~wd;
    end while (!rdy[d] && l < 20);
    rdat = din_o[d]; ren_s[d] = 1'b0; wen_s[d] = 1'b0;
    @(posedge clk); #1; g = rdy[d];
    if (r && w) begin err_m[d] = 1'b1; din_m[d] = 16'h0000; end
    else if (r) din_m[d] = a == IO ? io_m[d] : ram_m[d][a[7:0]];
    else if (w) begin if (a == IO) io_m[d] = wd; else ram_m[d][a[7:0]] = wd; end
  endtask
  task automatic do_reset(input int d);
    rst_s[d] = 1'b1; ren_s[d] = 1'b0; wen_s[d] = 1'b0;
    @(posedge clk); #1; rst_s[d] = 1'b0;
    io_m[d] = 16'h0000; din_m[d] = 16'h0000; err_m[d] = 1'b0;
  endtask
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      n_cmp++; if (din_o[d] !== 16'h0000) begin n_err++; $display("FAIL reset_data_in[%0d] got=%h exp=0000", d, din_o[d]); end
      n_cmp++; if (rdy[d] !== 1'b0) begin n_err++; $display("FAIL reset_ready[%0d] got=%b exp=0", d, rdy[d]); end
      n_cmp++; if (io_o[d] !== 16'h0000) begin n_err++; $display("FAIL reset_io[%0d] got=%h exp=0000", d, io_o[d]); end
      n_cmp++; if (err_o[d] !== 1'b0) begin n_err++; $display("FAIL reset_err[%0d] got=%b exp=0", d, err_o[d]); end
    end
  endtask
  task automatic test_basic();
    txn(0, 0, 1, 16'h0010, 16'h1234, lat, rd, gap);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL basic_wr_lat got=%0d exp=1", lat); end
    n_cmp++; if (gap !== 1'b0) begin n_err++; $display("FAIL basic_ready_gap got=%b exp=0", gap); end
    txn(0, 1, 0, 16'h0010, 16'h0000, lat, rd, gap);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL basic_rd_lat got=%0d exp=1", lat); end
    n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL basic_rd_data got=%h exp=1234", rd); end
  endtask
  task automatic test_wait();
    txn(1, 0, 1, 16'h0010, 16'hA5A5, lat, rd, gap);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wait_wr_lat got=%0d exp=4", lat); end
    txn(1, 0, 1, 16'h0050, 16'h0F0F, lat, rd, gap);
    txn(1, 1, 0, 16'h0010, 16'h0000, lat, rd, gap);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wait_rd_lat got=%0d exp=4", lat); end
    n_cmp++; if (rd !== 16'hA5A5) begin n_err++; $display("FAIL wait_rd_held_addr got=%h exp=a5a5", rd); end
    txn(1, 1, 0, 16'h0050, 16'h0000, lat, rd, gap);
    n_cmp++; if (rd !== 16'h0F0F) begin n_err++; $display("FAIL wait_rd_other got=%h exp=0f0f", rd); end
  endtask
  task automatic test_io();
    txn(0, 0, 1, 16'h0000, 16'h0077, lat, rd, gap);
    txn(0, 0, 1, IO, 16'hBEEF, lat, rd, gap);
    n_cmp++; if (io_o[0] !== 16'hBEEF) begin n_err++; $display("FAIL io_out got=%h exp=beef", io_o[0]); end
    txn(0, 1, 0, 16'h0000, 16'h0000, lat, rd, gap);
    n_cmp++; if (rd !== 16'h0077) begin n_err++; $display("FAIL io_ram0_kept got=%h exp=0077", rd); end
    txn(0, 1, 0, IO, 16'h0000, lat, rd, gap);
    n_cmp++; if (rd !== 16'hBEEF) begin n_err++; $display("FAIL io_readback got=%h exp=beef", rd); end
  endtask
  task automatic test_alias();
    txn(0, 0, 1, 16'h0105, 16'h00AA, lat, rd, gap);
    txn(0, 1, 0, 16'h0005, 16'h0000, lat, rd, gap);
    n_cmp++; if (rd !== 16'h00AA) begin n_err++; $display("FAIL alias_rd got=%h exp=00aa", rd); end
  endtask
  task automatic test_err();
    txn(0, 0, 1, 16'h0020, 16'h5555, lat, rd, gap);
    txn(0, 1, 1, 16'h0020, 16'hDEAD, lat, rd, gap);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL err_lat got=%0d exp=1", lat); end
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL err_data_in got=%h exp=0000", rd); end
    n_cmp++; if (err_o[0] !== 1'b1) begin n_err++; $display("FAIL err_flag got=%b exp=1", err_o[0]); end
    txn(0, 1, 0, 16'h0020, 16'h0000, lat, rd, gap);
    n_cmp++; if (rd !== 16'h5555) begin n_err++; $display("FAIL err_no_write got=%h exp=5555", rd); end
    n_cmp++; if (err_o[0] !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", err_o[0]); end
    do_reset(0);
    n_cmp++; if (err_o[0] !== 1'b0) begin n_err++; $display("FAIL err_cleared got=%b exp=0", err_o[0]); end
  endtask
  task automatic test_rst_mid();
    logic seen;
    txn(1, 0, 1, 16'h0030, 16'h3333, lat, rd, gap);
    txn(1, 0, 1, IO, 16'h7777, lat, rd, gap);
    txn(1, 1, 0, 16'h0030, 16'h0000, lat, rd, gap);
    txn(1, 1, 1, 16'h0044, 16'h0000, lat, rd, gap);
    ren_s[1] = 1'b0; wen_s[1] = 1'b1; addr_s[1] = 16'h0030; dout_s[1] = 16'h9999; seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= rdy[1]; end
    rst_s[1] = 1'b1;
    @(posedge clk); #1; seen |= rdy[1];
    rst_s[1] = 1'b0; wen_s[1] = 1'b0;
    io_m[1] = 16'h0000; din_m[1] = 16'h0000; err_m[1] = 1'b0;
    n_cmp++; if (din_o[1] !== 16'h0000 || io_o[1] !== 16'h0000 || err_o[1] !== 1'b0)
      begin n_err++; $display("FAIL rstmid_outputs got=%h/%h/%b exp=0000/0000/0", din_o[1], io_o[1], err_o[1]); end
    repeat (4) begin @(posedge clk); #1; seen |= rdy[1]; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_ready got=%b exp=0", seen); end
    txn(1, 1, 0, 16'h0030, 16'h0000, lat, rd, gap);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rstmid_next_lat got=%0d exp=4", lat); end
    n_cmp++; if (rd !== 16'h3333) begin n_err++; $display("FAIL rstmid_word_kept got=%h exp=3333", rd); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] pat;
    ren_s[0] = 1'b1; addr_s[0] = 16'h0010;
    for (int i = 3; i >= 0; i--) begin @(posedge clk); #1; pat[i] = rdy[0]; end
    ren_s[0] = 1'b0;
    @(posedge clk); #1;
    din_m[0] = 16'h1234;
    n_cmp++; if (pat !== 4'b1010) begin n_err++; $display("FAIL b2b_ready_pattern got=%b exp=1010", pat); end
    n_cmp++; if (din_o[0] !== 16'h1234) begin n_err++; $display("FAIL b2b_data got=%h exp=1234", din_o[0]); end
  endtask
  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) txn(d, 0, 1, 16'(i), 16'($urandom), lat, rd, gap);
      for (int n = 0; n < 120; n++) begin
        int k;
        logic [15:0] a, wd;
        bit r, w;
        k = $urandom_range(0, 9);
        a = 16'($urandom);
        wd = 16'($urandom);
        if (a == IO) a = a ^ 16'h0001;
        if (k == 1 || k == 2 || k == 3) a = IO;
        r = k == 0 || k == 3 || k >= 7;
        w = k == 0 || k == 1 || k == 2 || (k >= 4 && k <= 6);
        txn(d, r, w, a, wd, lat, rd, gap);
        n_cmp++; if (lat !== exp_lat(d)) begin n_err++; $display("FAIL rnd_lat[%0d] op=%0d got=%0d exp=%0d", d, n, lat, exp_lat(d)); end
        n_cmp++; if (rd !== din_m[d]) begin n_err++; $display("FAIL rnd_data[%0d] op=%0d a=%h got=%h exp=%h", d, n, a, rd, din_m[d]); end
        n_cmp++; if (io_o[d] !== io_m[d]) begin n_err++; $display("FAIL rnd_io[%0d] op=%0d got=%h exp=%h", d, n, io_o[d], io_m[d]); end
        n_cmp++; if (err_o[d] !== err_m[d]) begin n_err++; $display("FAIL rnd_err[%0d] op=%0d got=%b exp=%b", d, n, err_o[d], err_m[d]); end
        n_cmp++; if (gap !== 1'b0) begin n_err++; $display("FAIL rnd_gap[%0d] op=%0d got=%b exp=0", d, n, gap); end
      end
    end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; ren_s[d] = 1'b0; wen_s[d] = 1'b0; addr_s[d] = '0; dout_s[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wait();
    test_io();
    test_alias();
    test_err();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
